osc_capture_frame: RTL

Parametrised multi-channel capture engine sitting between signal_generator-style sample sources and the oscilloscope VGA renderer. It decimates incoming samples, arms on a pre-trigger fill, and detects a rising level crossing on a selectable channel. After the trigger it captures one screen-width frame into a double-buffered memory. The display side reads a stable, trigger-aligned frame by column while the next frame is being captured.

---
 rtl/osc_capture_frame.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/osc_capture_frame.sv
// Capture engine: decimate, pre-trigger fill, rising-level trigger, double-buffered frame (AUTO_TRIG_EN adds forced trigger).
// Readout latency 1 cycle; no backpressure, samples accepted while in DONE are not stored.
module osc_capture_frame #(
  parameter int CH           = 2,
  parameter int DW           = 16,
  parameter int DEPTH        = 640,
  parameter int PRE          = 64,
  parameter int DECIM_W      = 8,
  parameter int AUTO_TIMEOUT = 4096,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               CLOCK_50,
  input  logic               RESET_n,
  input  logic               SWTCH,
  input  logic               sample_valid,
  input  logic [CH*DW-1:0]   signal,
  input  logic [CHW-1:0]     trig_ch,
  input  logic [DW-1:0]      trig_level,
  input  logic [DECIM_W-1:0] decim,
  input  logic [AW-1:0]      rd_col,
  input  logic [CHW-1:0]     rd_ch,
  output logic [DW-1:0]      rd_data,
  output logic               frame_valid,
  output logic               frame_ready,
  output logic [1:0]         cap_state
);

  typedef enum logic [1:0] {S_ARM = 2'd0, S_WAIT = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;
  localparam int POSTN = DEPTH - PRE;

  state_t             r_state, w_state_nxt;
  logic [DECIM_W-1:0] r_dec_cnt;
  logic [AW-1:0]      r_wr_ptr, r_start_ptr, r_start_disp, r_arm_cnt, w_start;
  logic [AW:0]        r_post_cnt;
  logic [DW-1:0]      r_prev, w_cur;
  logic               r_prev_vld, r_cap_bank, r_frame_valid, r_frame_ready;
  logic               w_accept, w_wr_en, w_cross, w_timeout, w_trig;
  logic               w_arm_done, w_post_done, w_enter_done;
  logic [AW:0]        w_wr_addr, w_rd_addr, w_start_sum, w_rd_sum, w_rd_off;
  logic               r_rd_zero;
  logic [CHW-1:0]     r_rd_sel;
  logic [DW-1:0]      w_q [CH];

  assign w_accept = sample_valid && (r_dec_cnt == decim);

  always_comb begin
    w_cur = '0;
    for (int k = 0; k < CH; k++)
      if (int'(trig_ch) == k) w_cur = signal[k*DW +: DW];
  end

  assign w_cross = r_prev_vld && ($signed(r_prev) < $signed(trig_level)) &&
                   ($signed(w_cur) >= $signed(trig_level));

`ifdef AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;
  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n)                r_to_cnt <= '0;
    else if (r_state != S_WAIT)  r_to_cnt <= '0;
    else if (w_accept)           r_to_cnt <= r_to_cnt + 1'b1;
  end
  assign w_timeout = (r_to_cnt == TW'(AUTO_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_trig      = (r_state == S_WAIT) && w_accept && (w_cross || w_timeout);
  assign w_arm_done  = (PRE == 0) || (w_accept && (r_arm_cnt == AW'(PRE - 1)));
  assign w_post_done = w_accept && (r_post_cnt == (AW+1)'(POSTN - 1));

  // (wr_ptr - PRE) mod DEPTH without going negative
  always_comb begin
    w_start_sum = {1'b0, r_wr_ptr} + (AW+1)'(POSTN);
    if (w_start_sum >= (AW+1)'(DEPTH)) w_start_sum = w_start_sum - (AW+1)'(DEPTH);
    w_start = w_start_sum[AW-1:0];
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) r_state <= S_ARM;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ARM:  if (w_arm_done)  w_state_nxt = S_WAIT;
      S_WAIT: if (w_trig)      w_state_nxt = (POSTN == 1) ? S_DONE : S_POST;
      S_POST: if (w_post_done) w_state_nxt = S_DONE;
      S_DONE: if (!SWTCH)      w_state_nxt = S_ARM;
      default:                 w_state_nxt = S_ARM;
    endcase
  end

  always_comb begin
    w_wr_en      = w_accept && (r_state != S_DONE);
    w_enter_done = (r_state != S_DONE) && (w_state_nxt == S_DONE);
    cap_state    = r_state;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      r_dec_cnt     <= '0;
      r_wr_ptr      <= '0;
      r_arm_cnt     <= '0;
      r_post_cnt    <= '0;
      r_prev        <= '0;
      r_prev_vld    <= 1'b0;
      r_start_ptr   <= '0;
      r_start_disp  <= '0;
      r_cap_bank    <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_ready <= 1'b0;
    end else begin
      if (sample_valid) r_dec_cnt <= w_accept ? '0 : r_dec_cnt + 1'b1;
      if (w_accept) r_prev <= w_cur;
      // DONE clears it so the first sample of a new ARM cannot trigger
      if (r_state == S_DONE) r_prev_vld <= 1'b0;
      else if (w_accept)     r_prev_vld <= 1'b1;
      if (w_wr_en) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (r_state != S_ARM) r_arm_cnt <= '0;
      else if (w_accept)    r_arm_cnt <= r_arm_cnt + 1'b1;
      if (w_trig) begin
        r_post_cnt  <= (AW+1)'(1);
        r_start_ptr <= w_start;
      end else if ((r_state == S_POST) && w_accept) begin
        r_post_cnt  <= r_post_cnt + 1'b1;
      end
      r_frame_ready <= w_enter_done;
      if (w_enter_done) begin
        r_cap_bank    <= ~r_cap_bank;
        r_start_disp  <= (r_state == S_WAIT) ? w_start : r_start_ptr;
        r_frame_valid <= 1'b1;
      end
    end
  end

  assign frame_valid = r_frame_valid;
  assign frame_ready = r_frame_ready;

  assign w_wr_addr = r_cap_bank ? (AW+1)'(DEPTH) + {1'b0, r_wr_ptr} : {1'b0, r_wr_ptr};

  always_comb begin
    w_rd_sum = {1'b0, r_start_disp} + {1'b0, rd_col};
    w_rd_off = (w_rd_sum >= (AW+1)'(DEPTH)) ? w_rd_sum - (AW+1)'(DEPTH) : w_rd_sum;
    w_rd_addr = r_cap_bank ? w_rd_off : (AW+1)'(DEPTH) + w_rd_off;
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [DW-1:0] r_mem [0:2*DEPTH-1];
    logic [DW-1:0] r_q;
    always_ff @(posedge CLOCK_50) begin
      if (w_wr_en) r_mem[w_wr_addr] <= signal[k*DW +: DW];
      r_q <= r_mem[w_rd_addr];
    end
    assign w_q[k] = r_q;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      r_rd_zero <= 1'b1;
      r_rd_sel  <= '0;
    end else begin
      r_rd_zero <= !r_frame_valid || (int'(rd_col) >= DEPTH) || (int'(rd_ch) >= CH);
      r_rd_sel  <= rd_ch;
    end
  end

  always_comb begin
    rd_data = '0;
    if (!r_rd_zero)
      for (int k = 0; k < CH; k++)
        if (int'(r_rd_sel) == k) rd_data = w_q[k];
  end

endmodule
